rv32_decode_stage: RTL and testbench



---
 rtl/decode_pkg.sv | 56 +++++
 rtl/rv32_onehot_encoder.sv | 135 +++++++++++++
 rtl/rv32_decode_stage.sv | 111 +++++++++++
 tb/tb_rv32_decode_stage.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared RV32 decode constants: opcodes, funct fields, one-hot bit indices and immediate formats.
package decode_pkg;

  localparam int INSTR_W_DEF = 48;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;

  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SRL = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
  localparam logic [2:0] F3_LB  = 3'd0, F3_LH  = 3'd1, F3_LW  = 3'd2, F3_LBU  = 3'd4, F3_LHU = 3'd5;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_MUL = 3'd0, F3_MULH = 3'd1, F3_MULHSU = 3'd2, F3_MULHU = 3'd3;
  localparam logic [2:0] F3_DIV = 3'd4, F3_DIVU = 3'd5, F3_REM = 3'd6, F3_REMU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;

  localparam logic [31:0] WORD_ECALL = 32'h0000_0073, WORD_EBREAK = 32'h0010_0073;

  localparam logic [5:0] B_ADD  = 6'd0,  B_SUB  = 6'd1,  B_XOR   = 6'd2,  B_OR    = 6'd3;
  localparam logic [5:0] B_AND  = 6'd4,  B_SLL  = 6'd5,  B_SRL   = 6'd6,  B_SRA   = 6'd7;
  localparam logic [5:0] B_SLT  = 6'd8,  B_SLTU = 6'd9,  B_ADDI  = 6'd10, B_XORI  = 6'd11;
  localparam logic [5:0] B_ORI  = 6'd12, B_ANDI = 6'd13, B_SLLI  = 6'd14, B_SRLI  = 6'd15;
  localparam logic [5:0] B_SRAI = 6'd16, B_SLTI = 6'd17, B_SLTIU = 6'd18, B_LB    = 6'd19;
  localparam logic [5:0] B_LH   = 6'd20, B_LW   = 6'd21, B_LBU   = 6'd22, B_LHU   = 6'd23;
  localparam logic [5:0] B_SB   = 6'd24, B_SH   = 6'd25, B_SW    = 6'd26, B_BEQ   = 6'd27;
  localparam logic [5:0] B_BNE  = 6'd28, B_BLT  = 6'd29, B_BGE   = 6'd30, B_BLTU  = 6'd31;
  localparam logic [5:0] B_BGEU = 6'd32, B_JAL  = 6'd33, B_JALR  = 6'd34, B_LUI   = 6'd35;
  localparam logic [5:0] B_AUIPC = 6'd36, B_ECALL = 6'd37, B_EBREAK = 6'd38, B_FENCE = 6'd39;
  localparam logic [5:0] B_MUL  = 6'd40, B_MULH = 6'd41, B_MULHU = 6'd42, B_MULHSU = 6'd43;
  localparam logic [5:0] B_DIV  = 6'd44, B_DIVU = 6'd45, B_REM   = 6'd46, B_REMU  = 6'd47;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

  function automatic logic [31:0] imm_gen(input imm_fmt_e fmt, input logic [31:0] i);
    case (fmt)
      FMT_I:   return {{20{i[31]}}, i[31:20]};
      FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   return {i[31:12], 12'b0};
      FMT_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_onehot_encoder.sv
// Combinational RV32I(+M) instruction to one-hot op encoder with register fields and immediate.
// RV32M_DECODE_EN adds the multiply/divide group (bits 40-47); without it those words are illegal.
module rv32_onehot_encoder
  import decode_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic [31:0]        instr,
  output logic [INSTR_W-1:0] onehot,
  output logic               alu_en,
  output logic               illegal,
  output logic [31:0]        imm,
  output logic [4:0]         rs1_addr,
  output logic [4:0]         rs2_addr,
  output logic [4:0]         rd_addr
);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       hit;
  logic [5:0] idx;
  imm_fmt_e   fmt;
  logic [47:0] oh_full;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    hit = 1'b1;
    idx = B_ADD;
    fmt = FMT_R;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD:  idx = B_ADD;
            F3_SLL:  idx = B_SLL;
            F3_SLT:  idx = B_SLT;
            F3_SLTU: idx = B_SLTU;
            F3_XOR:  idx = B_XOR;
            F3_SRL:  idx = B_SRL;
            F3_OR:   idx = B_OR;
            default: idx = B_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD) idx = B_SUB;
        else if (f7 == F7_ALT && f3 == F3_SRL) idx = B_SRA;
`ifdef RV32M_DECODE_EN
        else if (f7 == F7_MULDIV) begin
          case (f3)
            F3_MUL:    idx = B_MUL;
            F3_MULH:   idx = B_MULH;
            F3_MULHSU: idx = B_MULHSU;
            F3_MULHU:  idx = B_MULHU;
            F3_DIV:    idx = B_DIV;
            F3_DIVU:   idx = B_DIVU;
            F3_REM:    idx = B_REM;
            default:   idx = B_REMU;
          endcase
        end
`endif
        else hit = 1'b0;
      end
      OPC_OPIMM: begin
        fmt = FMT_I;
        case (f3)
          F3_ADD:  idx = B_ADDI;
          F3_SLT:  idx = B_SLTI;
          F3_SLTU: idx = B_SLTIU;
          F3_XOR:  idx = B_XORI;
          F3_OR:   idx = B_ORI;
          F3_AND:  idx = B_ANDI;
          F3_SLL:  begin idx = B_SLLI; hit = (f7 == F7_BASE); end
          default: begin
            idx = (f7 == F7_ALT) ? B_SRAI : B_SRLI;
            hit = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
        endcase
      end
      OPC_LOAD: begin
        fmt = FMT_I;
        case (f3)
          F3_LB:   idx = B_LB;
          F3_LH:   idx = B_LH;
          F3_LW:   idx = B_LW;
          F3_LBU:  idx = B_LBU;
          F3_LHU:  idx = B_LHU;
          default: hit = 1'b0;
        endcase
      end
      OPC_STORE: begin
        fmt = FMT_S;
        case (f3)
          F3_LB:   idx = B_SB;
          F3_LH:   idx = B_SH;
          F3_LW:   idx = B_SW;
          default: hit = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        case (f3)
          F3_BEQ:  idx = B_BEQ;
          F3_BNE:  idx = B_BNE;
          F3_BLT:  idx = B_BLT;
          F3_BGE:  idx = B_BGE;
          F3_BLTU: idx = B_BLTU;
          F3_BGEU: idx = B_BGEU;
          default: hit = 1'b0;
        endcase
      end
      OPC_JAL:   begin fmt = FMT_J; idx = B_JAL; end
      OPC_JALR:  begin fmt = FMT_I; idx = B_JALR; hit = (f3 == 3'd0); end
      OPC_LUI:   begin fmt = FMT_U; idx = B_LUI; end
      OPC_AUIPC: begin fmt = FMT_U; idx = B_AUIPC; end
      OPC_SYSTEM: begin
        fmt = FMT_I;
        idx = (instr == WORD_EBREAK) ? B_EBREAK : B_ECALL;
        hit = (instr == WORD_ECALL) || (instr == WORD_EBREAK);
      end
      OPC_MISC:  begin fmt = FMT_I; idx = B_FENCE; hit = (f3 == 3'd0); end
      default:   hit = 1'b0;
    endcase
  end

  assign oh_full  = hit ? (48'd1 << idx) : 48'd0;
  assign onehot   = INSTR_W'(oh_full);
  assign illegal  = ~hit;
  assign alu_en   = hit && ((idx <= B_SLTIU) || (idx >= B_MUL));
  assign imm      = imm_gen(fmt, instr);
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rd_addr  = instr[11:7];

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32 decode stage: one-hot encoder feeding a main register backed by a one-entry skid.
// Build with RV32M_DECODE_EN to decode the M extension (passed down to the encoder).
module rv32_decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [31:0]        in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr_onehot,
  output logic               out_alu_en,
  output logic [4:0]         out_rs1_addr,
  output logic [4:0]         out_rs2_addr,
  output logic [4:0]         out_rd_addr,
  output logic [31:0]        out_imm,
  output logic [31:0]        out_pc,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_count
);

  typedef struct packed {
    logic [INSTR_W-1:0] onehot;
    logic               alu_en;
    logic               illegal;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [31:0]        imm;
    logic [31:0]        pc;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [INSTR_W-1:0] oh_p0;
  logic               alu_en_p0, illegal_p0;
  logic [4:0]         rs1_p0, rs2_p0, rd_p0;
  logic [31:0]        imm_p0;
  entry_t             dec_p0, ent_p1, skid_p1;
  logic               vld_p1, skid_vld_p1;
  logic               push, pop, main_free;

  // Stage 0: combinational decode of the fetch word
  rv32_onehot_encoder #(.INSTR_W(INSTR_W)) u_enc (
    .instr    (in_instr),
    .onehot   (oh_p0),
    .alu_en   (alu_en_p0),
    .illegal  (illegal_p0),
    .imm      (imm_p0),
    .rs1_addr (rs1_p0),
    .rs2_addr (rs2_p0),
    .rd_addr  (rd_p0)
  );

  assign dec_p0 = {oh_p0, alu_en_p0, illegal_p0, rs1_p0, rs2_p0, rd_p0, imm_p0, in_pc};

  assign in_ready  = ~skid_vld_p1;
  assign push      = in_valid && in_ready;
  assign pop       = vld_p1 && out_ready;
  assign main_free = ~vld_p1 || pop;

  // Stage 1: main output register; the skid only fills while main is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      ent_p1      <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (main_free) begin
      if (skid_vld_p1) begin
        ent_p1      <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= push;
        if (push) ent_p1 <= dec_p0;
      end
    end else if (push) begin
      skid_p1     <= dec_p0;
      skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_count <= '0;
    else if (pop && ent_p1.illegal && !flush) illegal_count <= sat_inc(illegal_count);
  end

  assign out_valid        = vld_p1;
  assign out_instr_onehot = ent_p1.onehot;
  assign out_alu_en       = ent_p1.alu_en;
  assign out_illegal      = ent_p1.illegal;
  assign out_rs1_addr     = ent_p1.rs1;
  assign out_rs2_addr     = ent_p1.rs2;
  assign out_rd_addr      = ent_p1.rd;
  assign out_imm          = ent_p1.imm;
  assign out_pc           = ent_p1.pc;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: decode table, skid/flush/counter sequences, randomized traffic vs a queue model.
module tb_rv32_decode_stage;

  localparam int INSTR_W = 48;
  localparam int CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [31:0]        in_instr = '0;
  logic [31:0]        in_pc = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [INSTR_W-1:0] out_instr_onehot;
  logic               out_alu_en;
  logic [4:0]         out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [31:0]        out_imm, out_pc;
  logic               out_illegal;
  logic [CNT_W-1:0]   illegal_count;

  always #5 clk = ~clk;

  rv32_decode_stage #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr_onehot(out_instr_onehot),
    .out_alu_en(out_alu_en), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .out_rd_addr(out_rd_addr), .out_imm(out_imm), .out_pc(out_pc),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Instruction set as mask/match pairs, indexed by one-hot bit.
  localparam logic [31:0] MR = 32'hFE00707F, MI = 32'h0000707F, MU = 32'h0000007F, MF = 32'hFFFFFFFF;
  localparam logic [31:0] MASK [48] = '{
    MR, MR, MR, MR, MR, MR, MR, MR, MR, MR,
    MI, MI, MI, MI, MR, MR, MR, MI, MI,
    MI, MI, MI, MI, MI, MI, MI, MI,
    MI, MI, MI, MI, MI, MI,
    MU, MI, MU, MU, MF, MF, MI,
    MR, MR, MR, MR, MR, MR, MR, MR};
  localparam logic [31:0] MATCH [48] = '{
    32'h00000033, 32'h40000033, 32'h00004033, 32'h00006033, 32'h00007033,
    32'h00001033, 32'h00005033, 32'h40005033, 32'h00002033, 32'h00003033,
    32'h00000013, 32'h00004013, 32'h00006013, 32'h00007013, 32'h00001013,
    32'h00005013, 32'h40005013, 32'h00002013, 32'h00003013,
    32'h00000003, 32'h00001003, 32'h00002003, 32'h00004003, 32'h00005003,
    32'h00000023, 32'h00001023, 32'h00002023,
    32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063, 32'h00006063, 32'h00007063,
    32'h0000006F, 32'h00000067, 32'h00000037, 32'h00000017,
    32'h00000073, 32'h00100073, 32'h0000000F,
    32'h02000033, 32'h02001033, 32'h02003033, 32'h02002033,
    32'h02004033, 32'h02005033, 32'h02006033, 32'h02007033};

  function automatic int ref_bit(input logic [31:0] w);
    int n = 40;
`ifdef RV32M_DECODE_EN
    n = 48;
`endif
    for (int k = 0; k < n; k++)
      if ((w & MASK[k]) == MATCH[k]) return k;
    return -1;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w, input int b);
    if (b <= 9 || b >= 40) return 32'h0;
    if (b >= 24 && b <= 26) return 32'($signed({w[31:25], w[11:7]}));
    if (b >= 27 && b <= 32) return 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    if (b == 33) return 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    if (b == 35 || b == 36) return w & 32'hFFFFF000;
    return 32'($signed(w[31:20]));
  endfunction

  typedef struct packed {
    logic [47:0] oh;
    logic        alu;
    logic        ill;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc;
  } exp_t;

  function automatic exp_t make_exp(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int b = ref_bit(w);
    e.oh  = (b >= 0) ? (48'd1 << b) : 48'd0;
    e.alu = (b >= 0) && (b <= 18 || b >= 40);
    e.ill = (b < 0);
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e.imm = (b >= 0) ? ref_imm(w, b) : 32'h0;
    e.pc  = pc;
    return e;
  endfunction

  // Queue model: entries held by the stage, oldest at the output.
  exp_t q[$];
  logic [CNT_W-1:0] cnt_m = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cnt_m = '0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_count", illegal_count, '0);
      check("rst_data", {out_instr_onehot, out_pc, out_imm}, '0);
    end else begin
      exp_t nxt;
      logic do_push, do_pop;
      check("m_out_valid", out_valid, q.size() != 0);
      check("m_in_ready", in_ready, q.size() < 2);
      check("m_count", illegal_count, cnt_m);
      if (q.size() != 0) begin
        check("m_fields", {out_instr_onehot, out_alu_en, out_illegal, out_rs1_addr,
                           out_rs2_addr, out_rd_addr, out_pc},
              {q[0].oh, q[0].alu, q[0].ill, q[0].rs1, q[0].rs2, q[0].rd, q[0].pc});
        if (!q[0].ill) check("m_imm", out_imm, q[0].imm);
      end
      do_push = in_valid && (q.size() < 2);
      do_pop  = (q.size() != 0) && out_ready;
      nxt     = make_exp(in_instr, in_pc);
      if (do_pop && q[0].ill && !flush && cnt_m != CNT_MAX) cnt_m = cnt_m + 1'b1;
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(nxt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    in_instr  = w;
    in_pc     = pc;
    out_ready = rdy;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    flush = 1'b0;
    #1 check("async_reset", out_valid, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] w;
    int          b;
    logic [31:0] imm;
  } tv_t;
  tv_t tv[$];

  task automatic add_tv(input logic [31:0] w, input int b, input logic [31:0] imm);
    tv_t t;
    t.w = w; t.b = b; t.imm = imm;
    tv.push_back(t);
  endtask

  localparam logic [31:0] ADD = 32'h002081B3, SUB = 32'h402081B3;
  localparam logic [31:0] MUL = 32'h022081B3, REMU = 32'h0220F1B3;

  initial begin
    int mb0, mb7;
    logic [47:0] eoh;
`ifdef RV32M_DECODE_EN
    mb0 = 40; mb7 = 47;
`else
    mb0 = -1; mb7 = -1;
`endif
    add_tv(ADD,          0,  32'h0);
    add_tv(32'hFFF00293, 10, 32'hFFFFFFFF);
    add_tv(SUB,          1,  32'h0);
    add_tv(32'h0020A423, 26, 32'h8);
    add_tv(32'hFE208EE3, 27, 32'hFFFFFFFC);
    add_tv(32'h0020F863, 32, 32'h10);
    add_tv(32'h008000EF, 33, 32'h8);
    add_tv(32'hFF9FF06F, 33, 32'hFFFFFFF8);
    add_tv(32'hABCDE3B7, 35, 32'hABCDE000);
    add_tv(32'h80000097, 36, 32'h80000000);
    add_tv(32'hFF010203, 19, 32'hFFFFFFF0);
    add_tv(32'h40315093, 16, 32'h403);
    add_tv(32'h02009093, -1, 32'h0);
    add_tv(32'h4020C1B3, -1, 32'h0);
    add_tv(32'h00000000, -1, 32'h0);
    add_tv(32'h00000073, 37, 32'h0);
    add_tv(32'h00100073, 38, 32'h1);
    add_tv(32'h0FF0000F, 39, 32'hFF);
    add_tv(MUL,          mb0, 32'h0);
    add_tv(REMU,         mb7, 32'h0);

    do_reset();

    for (int i = 0; i < tv.size(); i++) begin
      drive(1'b1, tv[i].w, 32'h100 + 32'(i * 4), 1'b1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      eoh = (tv[i].b >= 0) ? (48'd1 << tv[i].b) : 48'd0;
      check($sformatf("tv%0d_valid", i), out_valid, 1'b1);
      check($sformatf("tv%0d_onehot", i), out_instr_onehot, eoh);
      check($sformatf("tv%0d_illegal", i), out_illegal, tv[i].b < 0);
      check($sformatf("tv%0d_alu_en", i), out_alu_en,
            (tv[i].b >= 0) && (tv[i].b <= 18 || tv[i].b >= 40));
      check($sformatf("tv%0d_regs", i), {out_rs1_addr, out_rs2_addr, out_rd_addr},
            {tv[i].w[19:15], tv[i].w[24:20], tv[i].w[11:7]});
      check($sformatf("tv%0d_pc", i), out_pc, 32'h100 + 32'(i * 4));
      if (tv[i].b >= 0) check($sformatf("tv%0d_imm", i), out_imm, tv[i].imm);
      step();
    end

    // Skid: stall output, push add then sub, then drain
    drive(1'b1, ADD, 32'h200, 1'b0);
    step();
    drive(1'b1, SUB, 32'h204, 1'b0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("skid_full_in_ready", in_ready, 1'b0);
    check("skid_main_add", {out_valid, out_instr_onehot}, {1'b1, 48'd1});
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_first_add", {out_instr_onehot, out_pc}, {48'd1, 32'h200});
    step();
    @(negedge clk);
    check("drain_second_sub", {out_valid, out_instr_onehot, out_pc}, {1'b1, 48'd2, 32'h204});
    check("drain_in_ready_back", in_ready, 1'b1);
    step();
    @(negedge clk);
    check("drain_empty", out_valid, 1'b0);

    // Flush with both entries full
    step();
    drive(1'b1, ADD, 32'h300, 1'b0);
    step();
    drive(1'b1, SUB, 32'h304, 1'b0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_pre_full", in_ready, 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);

    // Word accepted in the flush cycle is dropped
    step();
    drive(1'b1, ADD, 32'h400, 1'b0);
    step();
    drive(1'b1, 32'h00108093, 32'h404, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_drop_0", out_valid, 1'b0);
    step();
    @(negedge clk);
    check("flush_drop_1", out_valid, 1'b0);

    // Illegal counter
    do_reset();
    drive(1'b1, 32'h0, 32'h500, 1'b1);
    step();
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("ill_flags", {out_illegal, out_alu_en, out_instr_onehot}, {1'b1, 1'b0, 48'd0});
    step();
    @(negedge clk);
    check("ill_count_2", illegal_count, CNT_W'(2));
    step();
    drive(1'b1, MUL, 32'h508, 1'b1);
    step();
    drive(1'b1, REMU, 32'h50C, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
`ifdef RV32M_DECODE_EN
    check("m_ext_count", illegal_count, CNT_W'(2));
`else
    check("m_ext_count", illegal_count, CNT_W'(4));
`endif

    // Saturation: stream illegal words well past the counter range
    step();
    drive(1'b1, 32'h0, 32'h600, 1'b1);
    for (int i = 0; i < 24; i++) step();
    @(negedge clk);
    check("sat_reached", illegal_count, CNT_MAX);
    step();
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    check("sat_hold", illegal_count, CNT_MAX);

    // Reset arriving while an entry is stalled at the output
    step();
    drive(1'b1, ADD, 32'h700, 1'b0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_valid", out_valid, 1'b1);
    do_reset();
    @(negedge clk);
    check("post_reset_empty", out_valid, 1'b0);

    // Randomized traffic against the queue model
    step();
    for (int c = 0; c < 3000; c++) begin
      int r, k;
      logic [31:0] w;
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 47);
      if (r < 6) w = ($urandom() & ~MASK[k]) | MATCH[k];
      else if (r < 8) w = $urandom();
      else w = 32'h0;
      drive($urandom_range(0, 3) != 0, w, $urandom(), $urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    flush = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
